// File: rtl/cpu_lsu_pkg.sv
// cpu_lsu_pkg: shared types and helpers for the load/store unit.
//   mem_op_t    - memory op encoding carried on req_op (OPW bits)
//   EXC_*       - exception codes driven on except_code
//   sb_entry_t  - one store-buffer entry {word addr, byte enables, lane data}
//   lane_be / misaligned / st_data / ld_data - little-endian lane helpers,
//   MIPS rules for the unaligned LWL/LWR/SWL/SWR family.
package cpu_lsu_pkg;

  localparam int OPW        = 4;
  localparam int LSU_AW_MAX = 32;  // widest ADDR_WIDTH the entry format holds

  typedef enum logic [OPW-1:0] {
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL,
    OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_SC
  } mem_op_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef struct packed {
    logic [LSU_AW_MAX-1:0] addr;  // word aligned
    logic [3:0]            be;
    logic [31:0]           data;  // already lane positioned
  } sb_entry_t;

  function automatic logic is_store(mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_SC};
  endfunction

  function automatic logic misaligned(mem_op_t op, logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH:        return a[0];
      OP_LW, OP_LL, OP_SW, OP_SC:  return |a;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(mem_op_t op, logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      OP_LWL, OP_SWL:       return 4'b1111 >> (2'd3 - a);  // bytes 0..a
      OP_LWR, OP_SWR:       return 4'b1111 << a;           // bytes a..3
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(mem_op_t op, logic [1:0] a, logic [31:0] rt);
    case (op)
      OP_SB:   return {4{rt[7:0]}};
      OP_SH:   return {2{rt[15:0]}};
      OP_SWL:  return rt >> {2'd3 - a, 3'b000};  // upper rt bytes to low lanes
      OP_SWR:  return rt << {a, 3'b000};         // low rt bytes to high lanes
      default: return rt;
    endcase
  endfunction

  // rd is the full bus word; old is rt for the partial-word merges
  function automatic logic [31:0] ld_data(mem_op_t op, logic [1:0] a,
                                          logic [31:0] rd, logic [31:0] old);
    logic [31:0] sh;
    logic [31:0] msk;
    sh = rd >> {a, 3'b000};
    case (op)
      OP_LB:  return {{24{sh[7]}}, sh[7:0]};
      OP_LBU: return {24'b0, sh[7:0]};
      OP_LH:  return {{16{sh[15]}}, sh[15:0]};
      OP_LHU: return {16'b0, sh[15:0]};
      OP_LWL: begin
        msk = 32'hFFFF_FFFF << {2'd3 - a, 3'b000};
        return (rd << {2'd3 - a, 3'b000}) | (old & ~msk);
      end
      OP_LWR: begin
        msk = 32'hFFFF_FFFF >> {a, 3'b000};
        return sh | (old & ~msk);
      end
      default: return rd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: DEPTH-entry FIFO of posted stores (DEPTH power of 2, >=2).
//   push/push_data - enqueue (caller guarantees !full or same-cycle pop)
//   pop            - dequeue head
//   full/empty     - occupancy flags
//   head           - oldest entry (valid when !empty)
//   youngest       - most recently pushed entry (valid when !empty)
module lsu_store_buffer
  import cpu_lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  sb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output sb_entry_t head,
  output sb_entry_t youngest
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign head     = mem[rd_ptr];
  assign youngest = mem[wr_ptr - 1'b1];

endmodule

// File: rtl/cpu_mem_lsu.sv
// cpu_mem_lsu: sequential load/store unit between EX/MEM and the data bus.
//   req_*      - op from EX/MEM, consumed when req_valid & req_ready
//   flush      - kill in-flight load; llbit_clear - drop LL/SC link
//   wb_*       - registered one-cycle write-back pulse
//   except_*   - registered AdEL/AdES/DBE pulse with faulting address
//   bus_*      - single-outstanding word bus; posted stores drain from the
//                store buffer, loads wait for the buffer to empty.
// Optional: define STORE_FORWARD_EN to serve loads fully covered by the
// youngest buffered store directly from the buffer.
module cpu_mem_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int SB_DEPTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OPW-1:0]        req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_waddr,
  input  logic                  flush,
  input  logic                  llbit_clear,
  output logic                  wb_valid,
  output logic [4:0]            wb_waddr,
  output logic [31:0]           wb_wdata,
  output logic                  stall,
  output logic                  except_occur,
  output logic [4:0]            except_code,
  output logic [ADDR_WIDTH-1:0] except_badvaddr,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [31:0]           bus_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LD_REQ, S_LD_WAIT, S_FLUSHED} state_t;
  localparam int TW = $clog2(LD_TIMEOUT + 1);

  state_t                st_q, st_d;
  mem_op_t               op, ld_op;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [31:0]           ld_old;
  logic [4:0]            ld_waddr;
  logic [TW-1:0]         tcnt;
  logic                  llbit;
  logic                  sb_full, sb_empty, sb_push, sb_pop, drain_ok;
  sb_entry_t             sb_in, sb_head, sb_young;
  logic                  is_st, misal, fwd_hit, timed_out;
  logic                  ld_start, ld_done, ld_to, sc_resp, fwd_done;
  logic [3:0]            req_be;

  assign op        = mem_op_t'(req_op);
  assign is_st     = is_store(op);
  assign misal     = misaligned(op, req_addr[1:0]);
  assign req_be    = lane_be(op, req_addr[1:0]);
  assign timed_out = (tcnt == TW'(LD_TIMEOUT - 1));

`ifdef STORE_FORWARD_EN
  // youngest entry wins over older ones, so it alone decides coverage
  assign fwd_hit = ~is_st & ~sb_empty &
                   (sb_young.addr[ADDR_WIDTH-1:2] == req_addr[ADDR_WIDTH-1:2]) &
                   ((req_be & ~sb_young.be) == 4'b0000);
`else
  logic unused_young;
  assign unused_young = ^{sb_young.addr, sb_young.be};
  assign fwd_hit = 1'b0;
`endif

  assign sb_in.addr = LSU_AW_MAX'({req_addr[ADDR_WIDTH-1:2], 2'b00});
  assign sb_in.be   = req_be;
  assign sb_in.data = st_data(op, req_addr[1:0], req_wdata);

  // stores drain whenever the bus is not owned by a load
  assign drain_ok = ~sb_empty & (st_q != S_LD_REQ) & (st_q != S_LD_WAIT);
  assign sb_pop   = drain_ok & bus_gnt;

  lsu_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .push     (sb_push),
    .push_data(sb_in),
    .pop      (sb_pop),
    .full     (sb_full),
    .empty    (sb_empty),
    .head     (sb_head),
    .youngest (sb_young)
  );

  always_comb begin
    st_d      = st_q;
    req_ready = 1'b0;
    sb_push   = 1'b0;
    ld_start  = 1'b0;
    ld_done   = 1'b0;
    ld_to     = 1'b0;
    sc_resp   = 1'b0;
    fwd_done  = 1'b0;
    case (st_q)
      S_IDLE: if (req_valid) begin
        if (misal) req_ready = 1'b1;
        else if (is_st) begin
          if (op == OP_SC && !llbit) begin
            req_ready = 1'b1;
            sc_resp   = 1'b1;
          end else if (!sb_full || sb_pop) begin
            req_ready = 1'b1;
            sb_push   = 1'b1;
            sc_resp   = (op == OP_SC);
          end
        end else if (fwd_hit) begin
          req_ready = 1'b1;
          fwd_done  = 1'b1;
        end else begin
          // load stays on req_* (stalled) until its data returns
          ld_start = 1'b1;
          st_d     = sb_empty ? S_LD_REQ : S_DRAIN;
        end
      end
      S_DRAIN:  if (flush) st_d = S_IDLE;
                else if (sb_empty) st_d = S_LD_REQ;
      // a granted request will still return data, so it must be swallowed
      S_LD_REQ: if (flush) st_d = bus_gnt ? S_FLUSHED : S_IDLE;
                else if (bus_gnt) st_d = S_LD_WAIT;
      S_LD_WAIT: begin
        if (flush) st_d = bus_rvalid ? S_IDLE : S_FLUSHED;
        else if (bus_rvalid) begin
          ld_done   = 1'b1;
          req_ready = 1'b1;
          st_d      = S_IDLE;
        end else if (timed_out) begin
          ld_to     = 1'b1;
          req_ready = 1'b1;
          st_d      = S_IDLE;
        end
      end
      S_FLUSHED: if (bus_rvalid || timed_out) st_d = S_IDLE;
      default:   st_d = S_IDLE;
    endcase
  end

  assign stall = req_valid & ~req_ready;

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = 32'b0;
    if (st_q == S_LD_REQ) begin
      bus_req  = 1'b1;
      bus_addr = {ld_addr[ADDR_WIDTH-1:2], 2'b00};
      bus_be   = lane_be(ld_op, ld_addr[1:0]);
    end else if (drain_ok) begin
      bus_req   = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = sb_head.addr[ADDR_WIDTH-1:0];
      bus_be    = sb_head.be;
      bus_wdata = sb_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q            <= S_IDLE;
      ld_op           <= OP_LB;
      ld_addr         <= '0;
      ld_old          <= '0;
      ld_waddr        <= '0;
      tcnt            <= '0;
      llbit           <= 1'b0;
      wb_valid        <= 1'b0;
      wb_waddr        <= '0;
      wb_wdata        <= '0;
      except_occur    <= 1'b0;
      except_code     <= '0;
      except_badvaddr <= '0;
    end else begin
      st_q         <= st_d;
      wb_valid     <= 1'b0;
      except_occur <= 1'b0;
      if (ld_start) begin
        ld_op    <= op;
        ld_addr  <= req_addr;
        ld_old   <= req_wdata;
        ld_waddr <= req_waddr;
      end
      if (st_q == S_LD_WAIT || st_q == S_FLUSHED) tcnt <= tcnt + 1'b1;
      else tcnt <= '0;
      if (st_q == S_IDLE && req_valid && misal) begin
        except_occur    <= 1'b1;
        except_code     <= is_st ? EXC_ADES : EXC_ADEL;
        except_badvaddr <= req_addr;
      end
      if (ld_to) begin
        except_occur    <= 1'b1;
        except_code     <= EXC_DBE;
        except_badvaddr <= ld_addr;
      end
      if (sc_resp) begin
        wb_valid <= 1'b1;
        wb_waddr <= req_waddr;
        wb_wdata <= {31'b0, llbit};
      end
      if (fwd_done) begin
        wb_valid <= 1'b1;
        wb_waddr <= req_waddr;
        wb_wdata <= ld_data(op, req_addr[1:0], sb_young.data, req_wdata);
      end
      if (ld_done) begin
        wb_valid <= 1'b1;
        wb_waddr <= ld_waddr;
        wb_wdata <= ld_data(ld_op, ld_addr[1:0], bus_rdata, ld_old);
      end
      if (llbit_clear) llbit <= 1'b0;
      else if ((ld_done && ld_op == OP_LL) || (fwd_done && op == OP_LL)) llbit <= 1'b1;
      else if (st_q == S_IDLE && req_valid && req_ready && op == OP_SC) llbit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_mem_lsu.sv
// tb_cpu_mem_lsu: directed vectors with hand-computed expectations for
// cpu_mem_lsu in its default build (no store forwarding).
module tb_cpu_mem_lsu;
  import cpu_lsu_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_waddr;
  logic        flush, llbit_clear;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        stall, except_occur;
  logic [4:0]  except_code;
  logic [31:0] except_badvaddr;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_cmp = 0;
  int n_err = 0;

  cpu_mem_lsu #(.SB_DEPTH(4), .ADDR_WIDTH(32), .LD_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_waddr(req_waddr),
    .flush(flush), .llbit_clear(llbit_clear),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .stall(stall), .except_occur(except_occur), .except_code(except_code),
    .except_badvaddr(except_badvaddr),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_op_t op, input logic [31:0] a, d, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    req_waddr = rd;
  endtask

  // full load handshake; bus grants immediately so pending stores drain first
  task automatic load_op(input mem_op_t op, input logic [31:0] a, old, rdat, exp,
                         input logic [3:0] be_exp, input string tag);
    int n;
    drive(op, a, old, 5'd9);
    bus_gnt = 1'b1;
    #1;
    n = 0;
    while (!(bus_req && !bus_we) && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_rdreq"}, {31'b0, bus_req & ~bus_we}, 32'd1);
    check({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    check({tag, "_be"}, {28'b0, bus_be}, {28'b0, be_exp});
    cyc();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = rdat;
    #1;
    check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    cyc();
    bus_rvalid = 1'b0;
    req_valid  = 1'b0;
    #1;
    check({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    check({tag, "_wbd"}, wb_wdata, exp);
    check({tag, "_wba"}, {27'b0, wb_waddr}, 32'd9);
  endtask

  logic [3:0]  be_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] ad_seq [4] = '{32'h400, 32'h400, 32'h400, 32'h404};

  initial begin
    int n;
    logic saw_wb;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    req_waddr = '0; flush = 1'b0; llbit_clear = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    cyc(); cyc();
    check("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check("rst_exc", {31'b0, except_occur}, 32'd0);
    check("rst_busreq", {31'b0, bus_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    cyc();

    // SW then LW to the same word: write goes out before the read
    drive(OP_SW, 32'h100, 32'h1234_5678, 5'd0);
    #1 check("sw_rdy", {31'b0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
    #1;
    check("sw_we", {31'b0, bus_req & bus_we}, 32'd1);
    check("sw_addr", bus_addr, 32'h100);
    check("sw_be", {28'b0, bus_be}, 32'hF);
    check("sw_data", bus_wdata, 32'h1234_5678);
    load_op(OP_LW, 32'h100, 32'h0, 32'h1234_5678, 32'h1234_5678, 4'b1111, "lw");

    // misaligned load / store
    drive(OP_LH, 32'h103, 32'h0, 5'd2);
    #1;
    check("adel_rdy", {31'b0, req_ready}, 32'd1);
    check("adel_bus", {31'b0, bus_req}, 32'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("adel_exc", {31'b0, except_occur}, 32'd1);
    check("adel_code", {27'b0, except_code}, 32'd4);
    check("adel_bad", except_badvaddr, 32'h103);
    check("adel_wb", {31'b0, wb_valid}, 32'd0);
    drive(OP_SW, 32'h102, 32'hFFFF_FFFF, 5'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("ades_code", {27'b0, except_code}, 32'd5);
    check("ades_exc", {31'b0, except_occur}, 32'd1);
    cyc();
    check("ades_pulse", {31'b0, except_occur}, 32'd0);
    check("ades_nobus", {31'b0, bus_req}, 32'd0);

    // five SB with the bus held off: fifth stalls until one drains
    for (int i = 0; i < 4; i++) begin
      drive(OP_SB, 32'h400 + i, 32'hA1 + i, 5'd0);
      #1 check("sb_rdy", {31'b0, req_ready}, 32'd1);
      cyc();
    end
    drive(OP_SB, 32'h404, 32'hA5, 5'd0);
    #1;
    check("sb5_rdy", {31'b0, req_ready}, 32'd0);
    check("sb5_stall", {31'b0, stall}, 32'd1);
    check("sb_be0", {28'b0, bus_be}, 32'h1);
    check("sb_wd0", bus_wdata, 32'hA1A1_A1A1);
    cyc();
    check("sb_hold", bus_addr, 32'h400);
    check("sb_hold_st", {31'b0, stall}, 32'd1);
    bus_gnt = 1'b1;
    #1 check("sb5_rdy_pop", {31'b0, req_ready}, 32'd1);
    cyc();
    bus_gnt = 1'b0;
    req_valid = 1'b0;
    #1;
    check("sb_wd1", bus_wdata, 32'hA2A2_A2A2);
    for (int k = 0; k < 4; k++) begin
      check("sb_be_seq", {28'b0, bus_be}, {28'b0, be_seq[k]});
      check("sb_ad_seq", bus_addr, ad_seq[k]);
      bus_gnt = 1'b1;
      cyc();
      bus_gnt = 1'b0;
      #1;
    end
    check("sb_empty", {31'b0, bus_req}, 32'd0);

    // SWL lane placement
    drive(OP_SWL, 32'h701, 32'hAABB_CCDD, 5'd0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("swl_be", {28'b0, bus_be}, 32'h3);
    check("swl_wd", bus_wdata, 32'h0000_AABB);
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;

    // LL / SC pair, then a failing SC
    load_op(OP_LL, 32'h200, 32'h0, 32'h80, 32'h80, 4'b1111, "ll");
    drive(OP_SC, 32'h200, 32'h0000_CAFE, 5'd3);
    #1 check("sc1_rdy", {31'b0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
    #1;
    check("sc1_wbv", {31'b0, wb_valid}, 32'd1);
    check("sc1_wbd", wb_wdata, 32'd1);
    check("sc1_st", {31'b0, bus_req & bus_we}, 32'd1);
    check("sc1_wd", bus_wdata, 32'h0000_CAFE);
    drive(OP_SC, 32'h200, 32'h0000_BEEF, 5'd4);
    #1 check("sc2_rdy", {31'b0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
    #1;
    check("sc2_wbv", {31'b0, wb_valid}, 32'd1);
    check("sc2_wbd", wb_wdata, 32'd0);
    check("sc2_wba", {27'b0, wb_waddr}, 32'd4);
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #1 check("sc2_nost", {31'b0, bus_req}, 32'd0);

    // extension and merge cases
    load_op(OP_LB,  32'h301, 32'h0, 32'h0000_8000, 32'hFFFF_FF80, 4'b0010, "lb");
    load_op(OP_LBU, 32'h301, 32'h0, 32'h0000_8000, 32'h0000_0080, 4'b0010, "lbu");
    load_op(OP_LH,  32'h302, 32'h0, 32'h8001_0000, 32'hFFFF_8001, 4'b1100, "lh");
    load_op(OP_LWL, 32'h501, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 4'b0011, "lwl");
    load_op(OP_LWR, 32'h502, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 4'b1100, "lwr");

    // load timeout -> DBE after LD_TIMEOUT cycles in LD_WAIT
    drive(OP_LW, 32'h600, 32'h0, 5'd5);
    bus_gnt = 1'b1;
    #1;
    n = 0;
    while (!(bus_req && !bus_we) && n < 20) begin cyc(); n++; end
    check("to_rdreq", {31'b0, bus_req & ~bus_we}, 32'd1);
    cyc();
    bus_gnt = 1'b0;
    #1;
    n = 1;
    saw_wb = 1'b0;
    while (!req_ready && n < 300) begin
      cyc();
      saw_wb |= wb_valid;
      n++;
    end
    check("to_cycles", n, 32'd255);
    cyc();
    req_valid = 1'b0;
    #1;
    check("to_exc", {31'b0, except_occur}, 32'd1);
    check("to_code", {27'b0, except_code}, 32'd7);
    check("to_bad", except_badvaddr, 32'h600);
    check("to_nowb", {31'b0, saw_wb | wb_valid}, 32'd0);

    // flush in LD_WAIT: the late rvalid must be dropped
    drive(OP_LW, 32'h700, 32'h0, 5'd7);
    bus_gnt = 1'b1;
    #1;
    n = 0;
    while (!(bus_req && !bus_we) && n < 20) begin cyc(); n++; end
    check("fl_rdreq", {31'b0, bus_req & ~bus_we}, 32'd1);
    cyc();
    bus_gnt   = 1'b0;
    flush     = 1'b1;
    req_valid = 1'b0;
    cyc();
    flush = 1'b0;
    cyc();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0000_DEAD;
    cyc();
    bus_rvalid = 1'b0;
    #1 check("fl_nowb0", {31'b0, wb_valid}, 32'd0);
    cyc();
    check("fl_nowb1", {31'b0, wb_valid}, 32'd0);
    load_op(OP_LBU, 32'h703, 32'h0, 32'h5A00_0000, 32'h0000_005A, 4'b1000, "post_fl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_lsu.md
Name: cpu_mem_lsu

Overview:
Sequential load/store unit that replaces the combinational MEM stage. It decodes load/store ops into byte-lane masks and does alignment checks. Stores are posted through a SB_DEPTH-entry store buffer. It tracks the LL/SC link bit and raises address-error exceptions. It sits between EX/MEM and the data bus, and drives pipeline stall and MEM/WB write-back.

Parameters:
SB_DEPTH, 4, store-buffer entries (power of 2, >=2)
ADDR_WIDTH, 32, byte address width
LD_TIMEOUT, 255, cycles a load may wait for bus_rvalid before bus-error exception

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  memory op present this cycle
req_ready  out  1  LSU accepts op this cycle
req_op  in  OPW  mem_op_t (LB,LBU,LH,LHU,LW,LWL,LWR,LL,SB,SH,SW,SWL,SWR,SC)
req_addr  in  ADDR_WIDTH  effective byte address
req_wdata  in  32  store data / old rt for LWL/LWR
req_waddr  in  5  destination register
flush  in  1  kill in-flight load (exception in later stage)
llbit_clear  in  1  ERET/exception clears link bit
wb_valid  out  1  write-back valid (1-cycle pulse)
wb_waddr  out  5  write-back register
wb_wdata  out  32  write-back data
stall  out  1  = req_valid & ~req_ready
except_occur  out  1  AdEL/AdES/bus-error pulse
except_code  out  5  4=AdEL, 5=AdES, 7=DBE
except_badvaddr  out  ADDR_WIDTH  faulting address
bus_req  out  1  bus request
bus_gnt  in  1  bus accepted request this cycle
bus_we  out  1  write
bus_addr  out  ADDR_WIDTH  word-aligned address
bus_be  out  4  byte enables
bus_wdata  out  32  lane-positioned write data
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data

Behaviour:
- Reset rst: synchronous, active-high. All outputs 0, FSM=IDLE, buffer empty, llbit=0, timeout counter 0.
- Alignment: LH/LHU/SH need addr[0]=0. LW/LL/SW/SC need addr[1:0]=0. Violation -> except pulse next cycle (AdEL for loads, AdES for stores), no bus access, no wb, op consumed.
- Lanes are little-endian. be is derived from op and addr[1:0]. SWL/SWR and LWL/LWR use standard MIPS lane rules. LWL/LWR merge bus_rdata into req_wdata under lane mask.
- Stores (SB/SH/SW/SWL/SWR, SC with llbit=1): enqueue {addr,be,data} when buffer not full. req_ready=1 in that cycle. No wb except SC, which writes rt=1 next cycle.
- SC with llbit=0: no enqueue, wb rt=0 next cycle. Any SC clears llbit.
- Buffer full and store req: req_ready=0 until an entry drains. Simultaneous drain+enqueue when full is allowed (count unchanged).
- Drain: head entry presented on bus whenever buffer non-empty and FSM not in LD_REQ/LD_WAIT. Entry popped on bus_gnt. The bus_* signals are held stable while bus_req=1 & ~bus_gnt.
- Load FSM:
  - IDLE: accepts a load. Goes to DRAIN if buffer non-empty, else LD_REQ. req_ready=0 until wb.
  - DRAIN: waits for buffer empty -> LD_REQ.
  - LD_REQ: bus_req=1, we=0; on bus_gnt -> LD_WAIT.
  - LD_WAIT: on bus_rvalid, wb_valid pulse with extended data -> IDLE, req_ready=1 that cycle. LL sets llbit.
- Timeout: the counter runs in LD_WAIT. Reaching LD_TIMEOUT -> DBE exception, -> IDLE, no wb.
- flush: in DRAIN/LD_REQ -> IDLE, no wb. In LD_WAIT -> FLUSHED state that discards the next rvalid, then IDLE. flush never affects buffered stores.
- llbit_clear has priority over LL set in the same cycle.
- Latency: store 1 cycle (posted). Load min 3 cycles (accept, gnt, rvalid) with empty buffer.

Optional Feature:
STORE_FORWARD_EN:
- Defined: a load whose word address matches the youngest buffered entry, and whose required bytes are all covered by that entry's be, takes data from the buffer. wb occurs the next cycle with no drain or bus access. Any partial overlap falls back to DRAIN.
- Undefined: loads always drain the buffer first.

Decomposition:
- Package cpu_lsu_pkg: mem_op_t enum, exception code constants, sb_entry_t struct {addr,be,data}, lane-mask/extension functions.
- Sub-module lsu_store_buffer (parametrised FIFO: push/pop/full/empty/head, plus youngest-entry port for forwarding).

Test Plan:
- SW 0x1234_5678 @0x100 then LW @0x100 (no forwarding) -> bus write be=1111 first, then read, wb=0x1234_5678 after drain.
- LH @0x103 -> except_code=4, badvaddr=0x103, no bus_req, no wb.
- Five back-to-back SB with bus_gnt=0 (SB_DEPTH=4) -> 5th stalls; after one gnt it enqueues; bus_be sequence matches addr[1:0].
- LL @0x200, rvalid data 0x80 -> llbit=1. SC -> wb 1 and store enqueued. Second SC -> wb 0, no store.
- LB @0x301, rdata 0x0000_8000 -> wb 0xFFFF_FF80. LBU same -> 0x0000_0080.
- Load with rvalid withheld 255 cycles -> DBE exception, no wb. flush during LD_WAIT -> late rvalid ignored.
